// File: rtl/ilowx_line_fill_responder.sv
// Line-fill responder: fetches a BLK_SIZE-bit line (or one word when uncached)
// over a 32-bit in-order memory port and returns it as a single-cycle response.
module ilowx_line_fill_responder #(
   parameter int BLK_SIZE  = 128,
   parameter int XLEN      = 32,
   parameter int MAX_OUTST = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                lowx_req_valid_i,
   input  logic [XLEN-1:0]     lowx_req_addr_i,
   input  logic                lowx_req_uncached_i,
   input  logic                lowx_req_ready_i,
   output logic                lowx_res_valid_o,
   output logic [BLK_SIZE-1:0] lowx_res_blk_o,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic [XLEN-1:0]     mem_addr_o,
   input  logic                mem_rvalid_i,
   input  logic [31:0]         mem_rdata_i
);
   localparam int BEATS = BLK_SIZE / 32;
   localparam int CW    = $clog2(BEATS) + 1;
   localparam int LW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BYTES = BLK_SIZE / 8;

   typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

   state_t                 state_q, state_d;
   logic [XLEN-1:0]        addr_q;
   logic                   unc_q;
   logic [CW-1:0]          issue_q, recv_q;
   logic [BEATS-1:0][31:0] blk_q;
   logic                   res_valid_q;

   logic [CW-1:0]   nbeats, outst, recv_nx;
   logic [XLEN-1:0] base;
   logic [LW-1:0]   wr_lane;
   logic            issue_ok, rx;

   assign nbeats   = unc_q ? CW'(1) : CW'(BEATS);
   assign outst    = issue_q - recv_q;
   assign base     = addr_q & ~XLEN'(BYTES - 1);
   assign issue_ok = (state_q == FILL) && (issue_q < nbeats) && (outst < CW'(MAX_OUTST));
   assign rx       = (state_q == FILL) && mem_rvalid_i && (recv_q < nbeats);
   assign recv_nx  = recv_q + CW'(rx);
   // Uncached word lands in its natural lane; cached beats fill in arrival order.
   assign wr_lane  = unc_q ? addr_q[LW+1:2] : recv_q[LW-1:0];

   assign mem_req_valid_o  = issue_ok;
   assign mem_addr_o       = !issue_ok ? '0 :
                             unc_q ? {addr_q[XLEN-1:2], 2'b00} :
                             base + (XLEN'(issue_q) << 2);
   assign lowx_res_valid_o = res_valid_q;
   assign lowx_res_blk_o   = blk_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (lowx_req_valid_i) state_d = FILL;
         FILL: if (recv_nx == nbeats) state_d = RESP;
         RESP: if (lowx_req_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         unc_q       <= 1'b0;
         issue_q     <= '0;
         recv_q      <= '0;
         blk_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= (state_d == RESP);
         if (state_q == IDLE && lowx_req_valid_i) begin
            addr_q  <= lowx_req_addr_i;
            unc_q   <= lowx_req_uncached_i;
            issue_q <= '0;
            recv_q  <= '0;
            blk_q   <= '0;
         end
         if (issue_ok && mem_req_ready_i) issue_q <= issue_q + CW'(1);
         if (rx) begin
            recv_q <= recv_nx;
            for (int i = 0; i < BEATS; i++)
               if (wr_lane == LW'(i)) blk_q[i] <= mem_rdata_i;
         end
      end
   end
endmodule

// File: tb/tb_ilowx_line_fill_responder.sv
// Bench for ilowx_line_fill_responder: directed table, multi-cycle corner
// sequences and randomized fills against an address-level memory/line model.
module tb_ilowx_line_fill_responder;
   localparam int MAX_OUTST = 2;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         lowx_req_valid_i = 1'b0;
   logic [31:0]  lowx_req_addr_i = '0;
   logic         lowx_req_uncached_i = 1'b0;
   logic         lowx_req_ready_i = 1'b0;
   logic         lowx_res_valid_o;
   logic [127:0] lowx_res_blk_o;
   logic         mem_req_valid_o;
   logic         mem_req_ready_i = 1'b0;
   logic [31:0]  mem_addr_o;
   logic         mem_rvalid_i = 1'b0;
   logic [31:0]  mem_rdata_i = '0;

   ilowx_line_fill_responder #(.BLK_SIZE(128), .XLEN(32), .MAX_OUTST(MAX_OUTST)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lowx_req_valid_i(lowx_req_valid_i), .lowx_req_addr_i(lowx_req_addr_i),
      .lowx_req_uncached_i(lowx_req_uncached_i), .lowx_req_ready_i(lowx_req_ready_i),
      .lowx_res_valid_o(lowx_res_valid_o), .lowx_res_blk_o(lowx_res_blk_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_addr_o(mem_addr_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // memory model state (written only by the memory process)
   int          cyc = 0;
   logic [31:0] pend_a[$];
   int          pend_due[$];
   logic [31:0] issued[$];
   int          ret_cnt = 0;
   int          max_out = 0;
   int          stall_used = 0;
   // memory configuration (written only by the stimulus process)
   int          ready_mode = 0;
   int          lat_min = 1, lat_max = 1;
   logic [31:0] stall_addr = '0;
   int          stall_len = 0;
   logic [31:0] salt = 32'h1234_5678;

   int n_chk = 0, n_fail = 0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   // Memory: decides ready/rvalid for the coming edge, logs accepted reads.
   always @(negedge clk_i) begin
      logic rdy, ret;
      cyc++;
      rdy = (ready_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      if (stall_len > 0 && stall_used < stall_len && mem_req_valid_o && mem_addr_o == stall_addr) begin
         rdy = 1'b0;
         stall_used++;
      end
      ret = (pend_a.size() > 0) && (pend_due[0] <= cyc);
      mem_req_ready_i = rdy;
      mem_rvalid_i    = ret;
      mem_rdata_i     = ret ? memfn(pend_a[0]) : $urandom;
      if (mem_req_valid_o && rdy && !rst_i) begin
         pend_a.push_back(mem_addr_o);
         pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
         issued.push_back(mem_addr_o);
         if (pend_a.size() > max_out) max_out = pend_a.size();
      end
      if (ret) begin
         void'(pend_a.pop_front());
         void'(pend_due.pop_front());
         ret_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_zero_outs(input string nm);
      chk({nm, "_res_valid"}, lowx_res_valid_o, 0);
      chk({nm, "_mem_valid"}, mem_req_valid_o, 0);
      chk({nm, "_mem_addr"}, mem_addr_o, 0);
      chk({nm, "_blk"}, lowx_res_blk_o, 0);
   endtask

   // One complete fill: model expected reads/block, drive request, check.
   task automatic do_fill(input logic [31:0] a, input logic u, input int stall,
                          input int exp_lat, input string nm);
      logic [127:0] eb;
      logic [31:0]  ea[$];
      logic [31:0]  base, w;
      int           start, lat;
      bit           seen;
      salt  = $urandom;
      start = issued.size();
      base  = a & ~32'hF;
      eb    = '0;
      if (u) begin
         w = a & ~32'h3;
         ea.push_back(w);
         eb[32*a[3:2] +: 32] = memfn(w);
      end else begin
         for (int i = 0; i < 4; i++) begin
            w = base + 32'(4 * i);
            ea.push_back(w);
            eb[32*i +: 32] = memfn(w);
         end
      end
      @(negedge clk_i);
      lowx_req_valid_i = 1'b1; lowx_req_addr_i = a;
      lowx_req_uncached_i = u; lowx_req_ready_i = 1'b0;
      lat = 0; seen = 0;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge clk_i);
         lat++;
         if (lat == 1) lowx_req_valid_i = 1'b0;
         seen = lowx_res_valid_o;
      end
      if (!seen) begin
         n_chk++; n_fail++;
         $display("FAIL %s_timeout actual=no_response required=response", nm);
         return;
      end
      if (exp_lat > 0) chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_blk"}, lowx_res_blk_o, eb);
      for (int k = 1; k < stall; k++) begin
         @(negedge clk_i);
         chk({nm, "_hold_valid"}, lowx_res_valid_o, 1);
         chk({nm, "_hold_blk"}, lowx_res_blk_o, eb);
      end
      lowx_req_ready_i = 1'b1;
      @(negedge clk_i);
      lowx_req_ready_i = 1'b0;
      chk({nm, "_idle_after"}, lowx_res_valid_o, 0);
      chk({nm, "_nreads"}, issued.size() - start, ea.size());
      for (int i = 0; i < ea.size() && start + i < issued.size(); i++)
         chk($sformatf("%s_addr%0d", nm, i), issued[start + i], ea[i]);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        unc;
      int          stall;
      int          lat;
   } vec_t;

   initial begin
      vec_t vt[5];
      int   r0;
      bit   ok;
      vt[0] = '{32'h0000_1236, 1'b0, 0, 6};
      vt[1] = '{32'h8000_0008, 1'b1, 0, 3};
      vt[2] = '{32'hFFFF_FFF4, 1'b0, 0, 6};
      vt[3] = '{32'h0000_0000, 1'b0, 1, 6};
      vt[4] = '{32'hFFFF_FFFF, 1'b1, 2, 3};

      repeat (3) @(negedge clk_i);
      chk_zero_outs("in_reset");
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk_zero_outs("after_reset");

      for (int i = 0; i < 5; i++)
         do_fill(vt[i].addr, vt[i].unc, vt[i].stall, vt[i].lat, $sformatf("vec%0d", i));

      // memory stalls beat 2 for 3 cycles
      stall_addr = 32'h0000_1238; stall_len = 3;
      do_fill(32'h0000_1236, 1'b0, 0, 9, "backpressure");
      chk("stall_cycles", stall_used, 3);
      stall_len = 0;

      do_fill(32'h0000_2004, 1'b0, 4, 6, "resp_stall");

      // reset mid-fill after two beats returned
      salt = $urandom;
      @(negedge clk_i);
      lowx_req_valid_i = 1'b1; lowx_req_addr_i = 32'h0000_4000; lowx_req_uncached_i = 1'b0;
      r0 = ret_cnt; ok = 0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk_i);
         lowx_req_valid_i = 1'b0;
         ok = (ret_cnt - r0 >= 2);
      end
      chk("rst_two_beats_seen", ok, 1);
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1 chk_zero_outs("async_rst");
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 0; k < 50 && pend_a.size() > 0; k++) @(negedge clk_i);
      @(negedge clk_i);
      chk_zero_outs("stale_ignored");
      do_fill(32'h0000_4010, 1'b0, 0, 6, "after_rst");

      // randomized fills with random readiness and latency
      ready_mode = 1; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 25; i++)
         do_fill($urandom, ($urandom_range(3) == 0), $urandom_range(2), -1, $sformatf("rnd%0d", i));

      chk("max_outstanding", max_out, MAX_OUTST);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
